// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory controller: accepts one load/store per pipe_en pulse,
// waits for mem_rdy with a bounded timeout and holds the result until the pipeline advances.
module data_mem_ctrl #(
   parameter int TIMEOUT = 15,
   parameter int DW      = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pipe_en,
   input  logic          mem_re,
   input  logic          mem_we,
   input  logic [DW-1:0] addr,
   input  logic [DW-1:0] wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_rdy,
   output logic [DW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_rd_o,
   output logic          mem_wr_o,
   output logic [DW-1:0] rdata,
   output logic          rvalid,
   output logic          err,
   output logic          data_mem_access
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [7:0] TO_CNT  = 8'(TIMEOUT);
   localparam logic [7:0] CNT_MAX = 8'hFF;

   state_t        state_q, state_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          op_wr_q, op_wr_d;
   logic [DW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          rd_q, rd_d;
   logic          wr_q, wr_d;
   logic          rvalid_q, rvalid_d;
   logic          err_q, err_d;
   logic          acc_q, acc_d;

   // Next-state and datapath decode
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_wr_d  = op_wr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      rvalid_d = rvalid_q;
      err_d    = err_q;
      case (state_q)
         ST_IDLE: begin
            if (pipe_en && (mem_re || mem_we)) begin
               state_d = ST_BUSY;
               cnt_d   = 8'd0;
               addr_d  = addr;
               wdata_d = wdata;
               op_wr_d = mem_we;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (mem_rdy) begin
               state_d  = ST_DONE;
               rvalid_d = 1'b1;
               err_d    = 1'b0;
               if (op_wr_q) begin
                  rdata_d = rdata_q;
               end else begin
                  rdata_d = mem_rdata;
               end
            end else if (cnt_q == TO_CNT) begin
               state_d  = ST_DONE;
               rvalid_d = 1'b1;
               err_d    = 1'b1;
               rdata_d  = {DW{1'b1}};
            end else begin
               // saturate rather than wrap on an out-of-range TIMEOUT
               if (cnt_q == CNT_MAX) begin
                  cnt_d = cnt_q;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         ST_DONE: begin
            if (pipe_en) begin
               state_d  = ST_IDLE;
               rvalid_d = 1'b0;
               err_d    = 1'b0;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            rvalid_d = 1'b0;
            err_d    = 1'b0;
         end
      endcase
      // strobes and access flag are registered copies of the next state
      rd_d  = (state_d == ST_BUSY) && !op_wr_d;
      wr_d  = (state_d == ST_BUSY) && op_wr_d;
      acc_d = (state_d != ST_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 8'd0;
         op_wr_q  <= 1'b0;
         addr_q   <= {DW{1'b0}};
         wdata_q  <= {DW{1'b0}};
         rdata_q  <= {DW{1'b0}};
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         acc_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_wr_q  <= op_wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
         acc_q    <= acc_d;
      end
   end

   assign mem_addr        = addr_q;
   assign mem_wdata       = wdata_q;
   assign mem_rd_o        = rd_q;
   assign mem_wr_o        = wr_q;
   assign rdata           = rdata_q;
   assign rvalid          = rvalid_q;
   assign err             = err_q;
   assign data_mem_access = acc_q;

endmodule
